// File: rtl/apb_charmap_master.sv
// apb_charmap_master
// APB initiator that turns one command (start address, fill data, beat count)
// into a burst of single APB transfers on consecutive word addresses.
// Every beat is reported on a valid/ready response port. A slave error or an
// ACCESS phase that runs out of cycles ends the burst early.

module apb_charmap_master #(
    parameter int APB_ADDR_WIDTH = 14,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    input  logic [7:0]                req_len_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_last_o,

    output logic                      busy_o,

    output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
    output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
    output logic                      apb_pwrite_o,
    output logic                      apb_psel_o,
    output logic                      apb_penable_o,
    input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
    input  logic                      apb_pready_i,
    input  logic                      apb_pslverr_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [15:0]               TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_STEP    = APB_ADDR_WIDTH'(4);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_MASK    = ~(APB_ADDR_WIDTH'(3));

    logic [1:0]                r_state;
    logic                      r_started;
    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic [APB_DATA_WIDTH-1:0] r_wdata;
    logic                      r_write;
    logic [7:0]                r_len;
    logic [15:0]               r_cnt;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;
    logic                      r_last;

    logic w_accept;
    logic w_beatDone;
    logic w_timeout;
    logic w_rspDone;

    assign w_accept   = req_valid_i && req_ready_o;
    assign w_beatDone = (r_state == S_ACCESS) && apb_pready_i;
    assign w_timeout  = (r_state == S_ACCESS) && !apb_pready_i && (r_cnt == TIMEOUT_LAST);
    assign w_rspDone  = (r_state == S_RESP) && rsp_ready_i;

    // Keeps the command port closed during reset and opens it on the first clock afterwards
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    // Burst sequencing: IDLE -> SETUP -> ACCESS -> RESP, looping to SETUP until the last beat
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_accept) r_state <= S_SETUP;
                S_SETUP:  r_state <= S_ACCESS;
                S_ACCESS: if (w_beatDone || w_timeout) r_state <= S_RESP;
                S_RESP:   if (rsp_ready_i) r_state <= r_last ? S_IDLE : S_SETUP;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Captures the command and steps the word address / remaining count after each beat
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_len   <= 8'd0;
        end else if (w_accept) begin
            r_addr  <= req_addr_i & ADDR_MASK;
            r_wdata <= req_wdata_i;
            r_write <= req_write_i;
            r_len   <= req_len_i;
        end else if (w_rspDone && !r_last) begin
            r_addr  <= r_addr + ADDR_STEP;
            r_len   <= r_len - 8'd1;
        end
    end

    // Counts ACCESS cycles of the current beat; cleared in SETUP so every beat gets a full budget
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= 16'd0;
        end else if (r_state == S_SETUP) begin
            r_cnt <= 16'd0;
        end else if ((r_state == S_ACCESS) && !apb_pready_i) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Registers the beat result; read data and slave error are only trusted when pready is high
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_beatDone) begin
            r_rdata <= r_write ? '0 : apb_prdata_i;
            r_err   <= apb_pslverr_i;
            r_last  <= (r_len == 8'd0) || apb_pslverr_i;
        end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_last  <= 1'b1;
        end
    end

    assign req_ready_o   = (r_state == S_IDLE) && r_started;
    assign busy_o        = (r_state != S_IDLE);

    assign apb_psel_o    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign apb_penable_o = (r_state == S_ACCESS);
    assign apb_paddr_o   = r_addr;
    assign apb_pwdata_o  = r_wdata;
    assign apb_pwrite_o  = r_write;

    assign rsp_valid_o   = (r_state == S_RESP);
    assign rsp_rdata_o   = r_rdata;
    assign rsp_err_o     = r_err;
    assign rsp_last_o    = r_last;

endmodule

// File: tb/tb_apb_charmap_master.sv
// tb_apb_charmap_master
// Randomised and directed bursts against a queue-based reference model.
// The stimulus side predicts every APB beat and every response; an APB slave
// process and a response monitor consume those predictions independently.

module tb_apb_charmap_master;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic [7:0]    req_len_i = 8'd0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_last_o;
    logic          busy_o;
    logic [AW-1:0] apb_paddr_o;
    logic [DW-1:0] apb_pwdata_o;
    logic          apb_pwrite_o;
    logic          apb_psel_o;
    logic          apb_penable_o;
    logic [DW-1:0] apb_prdata_i = '0;
    logic          apb_pready_i = 1'b0;
    logic          apb_pslverr_i = 1'b0;

    apb_charmap_master #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_len_i    (req_len_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_last_o   (rsp_last_o),
        .busy_o       (busy_o),
        .apb_paddr_o  (apb_paddr_o),
        .apb_pwdata_o (apb_pwdata_o),
        .apb_pwrite_o (apb_pwrite_o),
        .apb_psel_o   (apb_psel_o),
        .apb_penable_o(apb_penable_o),
        .apb_prdata_i (apb_prdata_i),
        .apb_pready_i (apb_pready_i),
        .apb_pslverr_i(apb_pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] addr;
        bit            write;
        logic [DW-1:0] wdata;
        int            waits;
        bit            slverr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic [DW-1:0] rdata;
        bit            err;
        bit            last;
    } rsp_t;

    beat_t beatQ[$];
    rsp_t  rspQ[$];

    int total = 0;
    int bad   = 0;
    bit holdReady = 1'b0;

    beat_t curBeat;
    int    accCount = 0;
    bit    prevSetup = 1'b0;

    // Counts one comparison and reports it when the DUT value differs from the model value
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    // Counts a comparison that failed outright (unexpected event or expired wait)
    task automatic reportFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got event want none", name);
    endtask

    // Predicts the burst, queues the expected beats/responses, then hands the command to the DUT
    task automatic applyStimulus(input bit write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input int len, input bit randomBeats, input int fixedWaits, input int errBeat);
        int base;
        int cycles;
        base = (int'(addr) / 4) * 4;
        for (int i = 0; i <= len; i++) begin
            beat_t b;
            rsp_t  r;
            bit    timedOut;
            b.addr  = AW'((base + 4 * i) % (1 << AW));
            b.write = write;
            b.wdata = wdata;
            if (randomBeats) begin
                b.waits  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 3)) : int'($urandom_range(0, 2));
                b.slverr = ($urandom_range(0, 9) == 0);
                b.data   = $urandom;
            end else begin
                b.waits  = fixedWaits;
                b.slverr = (i == errBeat);
                b.data   = DW'(32'hA0 + i);
            end
            timedOut = (b.waits >= TO);
            r.err    = timedOut || b.slverr;
            r.rdata  = (write || timedOut) ? '0 : b.data;
            r.last   = (i == len) || r.err;
            beatQ.push_back(b);
            rspQ.push_back(r);
            if (r.last) break;
        end
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_write_i = write;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_len_i   = 8'(len);
        cycles = 0;
        while (!req_ready_o && cycles < 20000) begin
            @(negedge clk_i);
            cycles++;
        end
        if (!req_ready_o) begin
            reportFail("req_ready_timeout");
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = AW'($urandom);
        req_wdata_i = $urandom;
        req_len_i   = 8'($urandom);
        req_write_i = 1'($urandom);
    endtask

    // Waits (bounded) until every predicted beat and response has been consumed
    task automatic waitDone(input string name);
        int cycles = 0;
        do begin
            @(negedge clk_i);
            cycles++;
        end while ((rspQ.size() != 0 || beatQ.size() != 0 || busy_o) && cycles < 20000);
        if (rspQ.size() != 0 || beatQ.size() != 0 || busy_o) reportFail(name);
    endtask

    // APB slave: checks each beat against the prediction and answers with the predicted timing
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            apb_pready_i = 1'b0;
            accCount     = 0;
            prevSetup    = 1'b0;
        end else begin
            checkOutput("penable_without_psel", 64'(apb_penable_o & ~apb_psel_o), 64'd0);
            apb_pslverr_i = 1'($urandom);
            apb_prdata_i  = $urandom;
            apb_pready_i  = 1'b0;
            if (apb_psel_o && !apb_penable_o) begin
                if (prevSetup) reportFail("setup_longer_than_one_cycle");
                if (beatQ.size() == 0) begin
                    reportFail("setup_without_expected_beat");
                    curBeat.waits = 0;
                    curBeat.addr  = apb_paddr_o;
                end else begin
                    curBeat = beatQ.pop_front();
                    checkOutput("setup_paddr", 64'(apb_paddr_o), 64'(curBeat.addr));
                    checkOutput("setup_pwrite", 64'(apb_pwrite_o), 64'(curBeat.write));
                    if (curBeat.write) checkOutput("setup_pwdata", 64'(apb_pwdata_o), 64'(curBeat.wdata));
                end
                accCount  = 0;
                prevSetup = 1'b1;
            end else if (apb_psel_o && apb_penable_o) begin
                if (!prevSetup && accCount == 0) reportFail("access_without_setup");
                prevSetup = 1'b0;
                accCount++;
                checkOutput("access_paddr_stable", 64'(apb_paddr_o), 64'(curBeat.addr));
                if (accCount > ((curBeat.waits >= TO) ? TO : curBeat.waits + 1)) reportFail("access_overrun");
                if (accCount == curBeat.waits + 1) begin
                    apb_pready_i  = 1'b1;
                    apb_pslverr_i = curBeat.slverr;
                    apb_prdata_i  = curBeat.data;
                end
            end else begin
                if (prevSetup) reportFail("setup_not_followed_by_access");
                if (accCount > 0)
                    checkOutput("access_cycles", 64'(accCount),
                                64'((curBeat.waits >= TO) ? TO : curBeat.waits + 1));
                prevSetup = 1'b0;
                accCount  = 0;
            end
        end
    end

    // Response monitor: compares every presented response with the queue head, pops on handshake
    always @(negedge clk_i) begin
        bit nextReady;
        if (rstn_i) begin
            checkOutput("rsp_valid_with_psel", 64'(rsp_valid_o & apb_psel_o), 64'd0);
            if (rsp_valid_o) begin
                if (rspQ.size() == 0) begin
                    reportFail("unexpected_response");
                end else begin
                    checkOutput("rsp_rdata", 64'(rsp_rdata_o), 64'(rspQ[0].rdata));
                    checkOutput("rsp_err", 64'(rsp_err_o), 64'(rspQ[0].err));
                    checkOutput("rsp_last", 64'(rsp_last_o), 64'(rspQ[0].last));
                end
            end
            nextReady   = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
            rsp_ready_i = nextReady;
            if (rsp_valid_o && nextReady && rspQ.size() > 0) void'(rspQ.pop_front());
        end else begin
            rsp_ready_i = 1'b0;
        end
    end

    // Checks that every output sits at its reset value
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_paddr"},     64'(apb_paddr_o),   64'd0);
        checkOutput({tag, "_pwdata"},    64'(apb_pwdata_o),  64'd0);
        checkOutput({tag, "_pwrite"},    64'(apb_pwrite_o),  64'd0);
        checkOutput({tag, "_psel"},      64'(apb_psel_o),    64'd0);
        checkOutput({tag, "_penable"},   64'(apb_penable_o), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid_o),   64'd0);
        checkOutput({tag, "_rsp_err"},   64'(rsp_err_o),     64'd0);
        checkOutput({tag, "_rsp_last"},  64'(rsp_last_o),    64'd0);
        checkOutput({tag, "_rsp_rdata"}, 64'(rsp_rdata_o),   64'd0);
        checkOutput({tag, "_busy"},      64'(busy_o),        64'd0);
        checkOutput({tag, "_req_ready"}, 64'(req_ready_o),   64'd0);
    endtask

    initial begin
        int cycles;

        $display("[TB] reset phase");
        #3;
        checkResetOutputs("reset");
        repeat (3) @(posedge clk_i);
        #1;
        checkResetOutputs("reset_clocked");
        @(negedge clk_i);
        #2;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("ready_after_reset", 64'(req_ready_o), 64'd1);

        $display("[TB] single write with two wait states");
        applyStimulus(1'b1, 14'h0010, 32'h0000_4141, 0, 1'b0, 2, -1);
        waitDone("write_single_done");

        $display("[TB] four-beat read with minimum latency");
        applyStimulus(1'b0, 14'h2580, 32'h0, 3, 1'b0, 0, -1);
        @(negedge clk_i);
        checkOutput("lat_setup_psel", 64'(apb_psel_o), 64'd1);
        checkOutput("lat_setup_penable", 64'(apb_penable_o), 64'd0);
        @(negedge clk_i);
        checkOutput("lat_access_penable", 64'(apb_penable_o & apb_psel_o), 64'd1);
        @(negedge clk_i);
        checkOutput("lat_rsp_valid", 64'(rsp_valid_o), 64'd1);
        waitDone("read_burst_done");

        $display("[TB] write burst aborted by slave error");
        applyStimulus(1'b1, 14'h1234, 32'hDEAD_BEEF, 2, 1'b0, 0, 1);
        waitDone("slverr_burst_done");

        $display("[TB] read timeout");
        applyStimulus(1'b0, 14'h0100, 32'h0, 0, 1'b0, 10, -1);
        waitDone("timeout_done");

        $display("[TB] address wrap");
        applyStimulus(1'b0, 14'h3FFC, 32'h0, 1, 1'b0, 1, -1);
        waitDone("wrap_done");

        $display("[TB] long burst across the wrap point");
        applyStimulus(1'b1, 14'h3F02, 32'h5A5A_A5A5, 255, 1'b0, 0, -1);
        waitDone("long_burst_done");

        $display("[TB] randomised back-to-back bursts");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 5)), 1'b1, 0, -1);
        end
        waitDone("random_done");

        $display("[TB] reset while a response is stalled");
        holdReady = 1'b1;
        applyStimulus(1'b0, 14'h0400, 32'h0, 3, 1'b0, 0, -1);
        cycles = 0;
        while (!rsp_valid_o && cycles < 50) begin
            @(negedge clk_i);
            cycles++;
        end
        if (!rsp_valid_o) reportFail("stall_rsp_valid_timeout");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            checkOutput("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
            checkOutput("stall_psel", 64'(apb_psel_o), 64'd0);
        end
        @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        checkResetOutputs("midburst_reset");
        beatQ.delete();
        rspQ.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        rstn_i = 1'b1;
        holdReady = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("ready_after_midburst_reset", 64'(req_ready_o), 64'd1);
        checkOutput("idle_after_midburst_reset", 64'(busy_o), 64'd0);

        $display("[TB] recovery burst");
        applyStimulus(1'b0, 14'h0808, 32'h0, 1, 1'b0, 0, -1);
        waitDone("recovery_done");

        checkOutput("leftover_responses", 64'(rspQ.size()), 64'd0);
        checkOutput("leftover_beats", 64'(beatQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
